// File: rtl/ysyx_22050612_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner
// encoding and default bus widths.
package ysyx_22050612_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22050612_arb_prio.sv
// Grant selection between IFU and LSU: the LSU normally wins, but after
// MAX_LSU_STREAK consecutive LSU grants with the IFU waiting, the IFU goes next.
module ysyx_22050612_arb_prio
  import ysyx_22050612_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic accept,
  input  logic idle,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam int unsigned SW = $clog2(MAX_LSU_STREAK + 1);

  logic [SW-1:0] lsu_streak;
  logic          streak_full;

  assign streak_full = (lsu_streak == SW'(MAX_LSU_STREAK));

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (idle) begin
      if (lsu_valid && !(ifu_valid && streak_full)) grant_lsu = 1'b1;
      else if (ifu_valid)                           grant_ifu = 1'b1;
    end
  end

  // Streak only grows while the IFU is actually being made to wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_streak <= '0;
    end else if (accept) begin
      if (grant_lsu && ifu_valid) begin
        if (!streak_full) lsu_streak <= lsu_streak + 1'b1;
      end else begin
        lsu_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU reads and
// LSU reads/writes, with IFU starvation protection and a response timeout.
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic                ifu_resp_err,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic                lsu_resp_err,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                stray_resp
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e          state, state_nxt;
  arb_owner_e          owner;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                grant_ifu, grant_lsu;
  logic                ifu_acc, lsu_acc, accept;
  logic                timed_out, resp_done, resp_err;

  ysyx_22050612_arb_prio #(
    .MAX_LSU_STREAK(MAX_LSU_STREAK)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .ifu_valid(ifu_req_valid),
    .lsu_valid(lsu_req_valid),
    .accept   (accept),
    .idle     (state == S_IDLE),
    .grant_ifu(grant_ifu),
    .grant_lsu(grant_lsu)
  );

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign ifu_acc       = ifu_req_valid && ifu_req_ready;
  assign lsu_acc       = lsu_req_valid && lsu_req_ready;
  assign accept        = ifu_acc || lsu_acc;
  assign timed_out     = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt = state;
    resp_done = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_resp_valid || timed_out) begin
          resp_done = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A real response wins over a timeout landing in the same cycle.
  assign resp_err       = resp_done && !mem_resp_valid;
  assign ifu_resp_valid = resp_done && (owner == OWNER_IFU);
  assign lsu_resp_valid = resp_done && (owner == OWNER_LSU);
  assign ifu_resp_err   = ifu_resp_valid && resp_err;
  assign lsu_resp_err   = lsu_resp_valid && resp_err;
  assign ifu_rdata      = (ifu_resp_valid && !resp_err) ? mem_rdata : '0;
  assign lsu_rdata      = (lsu_resp_valid && !resp_err) ? mem_rdata : '0;

  assign mem_req_valid  = (state == S_REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign busy           = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWNER_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wait_cnt   <= '0;
      stray_resp <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner   <= lsu_acc ? OWNER_LSU : OWNER_IFU;
        addr_q  <= lsu_acc ? lsu_addr : ifu_addr;
        wen_q   <= lsu_acc && lsu_wen;
        wdata_q <= lsu_acc ? lsu_wdata : '0;
        wmask_q <= lsu_acc ? lsu_wmask : '0;
      end
      if (state == S_REQ)                     wait_cnt <= '0;
      else if (state == S_WAIT && !timed_out) wait_cnt <= wait_cnt + 1'b1;
      if (mem_resp_valid && state != S_WAIT) stray_resp <= 1'b1;
    end
  end

endmodule
